// File: rtl/rv32ima_pkg.sv
// Shared types for the register-file access path: register index, issue and operand packets.
package rv32ima_pkg;

  localparam int NREGS_DEF = 32;
  localparam int REG_W     = $clog2(NREGS_DEF);

  typedef logic [REG_W-1:0] reg_t;

  localparam reg_t REG_ZERO = '0;

  typedef struct packed {
    reg_t rs1;
    reg_t rs2;
    reg_t rd;
    logic wr;
  } issue_pkt_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    reg_t        rd;
    logic        wr;
  } opnd_pkt_t;

  // True when an active write port targets the given register index.
  function automatic logic idx_match(input reg_t wr_idx, input reg_t rd_idx, input logic en);
    return en && (wr_idx == rd_idx);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set wins over clear, x0 never busy.
module regfile_scoreboard #(
  parameter int NREGS = 32,
  parameter int RW    = 5
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             set_en,
  input  logic [RW-1:0]    set_idx,
  input  logic             clr_en,
  input  logic [RW-1:0]    clr_idx,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:1] busy_reg;
  logic [NREGS-1:1] busy_next;

  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_bit
      always_comb begin
        busy_next[gi] = busy_reg[gi];
        if (set_en && (set_idx == RW'(gi))) begin
          busy_next[gi] = 1'b1;
        end else if (clr_en && (clr_idx == RW'(gi))) begin
          busy_next[gi] = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (nrst) begin
          busy_reg[gi] <= 1'b0;
        end else begin
          busy_reg[gi] <= busy_next[gi];
        end
      end
    end
  endgenerate

  assign busy = {busy_reg, 1'b0};

endmodule

// File: rtl/regfile_access_ctrl.sv
// Register-file initiator: hazard-checked issue, operand capture into a one-entry stage, writeback port.
// Build option REGFILE_BYPASS_EN forwards the write port into captured operands instead of stalling.
module regfile_access_ctrl
  import rv32ima_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int RW    = 5
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [RW-1:0]    issue_rs1,
  input  logic [RW-1:0]    issue_rs2,
  input  logic [RW-1:0]    issue_rd,
  input  logic             issue_wr,
  output logic [RW-1:0]    rsel1,
  output logic [RW-1:0]    rsel2,
  input  logic [31:0]      rdat1,
  input  logic [31:0]      rdat2,
  output logic [RW-1:0]    wsel,
  output logic             wen,
  output logic [31:0]      wdat,
  output logic             opnd_valid,
  input  logic             opnd_ready,
  output logic [31:0]      opnd_a,
  output logic [31:0]      opnd_b,
  output logic [RW-1:0]    opnd_rd,
  output logic             opnd_wr,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [RW-1:0]    wb_rd,
  input  logic [31:0]      wb_data,
  output logic [NREGS-1:0] busy
);

  issue_pkt_t       issue;
  opnd_pkt_t        opnd_reg, opnd_next;
  logic             opnd_valid_reg, opnd_valid_next;
  logic [NREGS-1:0] busy_vec;
  logic             wen_int;
  logic             fwd1, fwd2, fwd_rd;
  logic             raw1, raw2, waw;
  logic             stage_free, issue_ready_int, accept;

  assign issue = {issue_rs1, issue_rs2, issue_rd, issue_wr};

  // Writes pass straight through; x0 writes and writes during reset are suppressed.
  assign wen_int  = wb_valid && !nrst && (wb_rd != REG_ZERO);
  assign wen      = wen_int;
  assign wsel     = wb_rd;
  assign wdat     = wb_data;
  assign wb_ready = 1'b1;
  assign rsel1    = issue.rs1;
  assign rsel2    = issue.rs2;

  assign fwd1   = idx_match(wb_rd, issue.rs1, wen_int);
  assign fwd2   = idx_match(wb_rd, issue.rs2, wen_int);
  assign fwd_rd = idx_match(wb_rd, issue.rd, wen_int);

`ifdef REGFILE_BYPASS_EN
  assign raw1 = busy_vec[issue.rs1] && !fwd1;
  assign raw2 = busy_vec[issue.rs2] && !fwd2;
`else
  // Without forwarding, a source being written this cycle is read back next cycle.
  assign raw1 = busy_vec[issue.rs1] || fwd1;
  assign raw2 = busy_vec[issue.rs2] || fwd2;
`endif
  assign waw  = issue.wr && busy_vec[issue.rd] && !fwd_rd;

  assign stage_free      = !opnd_valid_reg || opnd_ready;
  assign issue_ready_int = stage_free && !raw1 && !raw2 && !waw;
  assign accept          = issue_valid && issue_ready_int;
  assign issue_ready     = issue_ready_int;

  function automatic logic [31:0] pick_opnd(input reg_t rs, input logic [31:0] rdat, input logic fwd);
    logic [31:0] val;
    val = rdat;
`ifdef REGFILE_BYPASS_EN
    if (fwd) val = wdat;
`else
    if (fwd) val = rdat;
`endif
    if (rs == REG_ZERO) val = '0;
    return val;
  endfunction

  always_comb begin
    opnd_next       = opnd_reg;
    opnd_valid_next = opnd_valid_reg;
    if (accept) begin
      opnd_valid_next = 1'b1;
      opnd_next.a     = pick_opnd(issue.rs1, rdat1, fwd1);
      opnd_next.b     = pick_opnd(issue.rs2, rdat2, fwd2);
      opnd_next.rd    = issue.rd;
      opnd_next.wr    = issue.wr;
    end else if (opnd_ready) begin
      opnd_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      opnd_valid_reg <= 1'b0;
      opnd_reg       <= '0;
    end else begin
      opnd_valid_reg <= opnd_valid_next;
      opnd_reg       <= opnd_next;
    end
  end

  assign opnd_valid = opnd_valid_reg;
  assign opnd_a     = opnd_reg.a;
  assign opnd_b     = opnd_reg.b;
  assign opnd_rd    = opnd_reg.rd;
  assign opnd_wr    = opnd_reg.wr;

  regfile_scoreboard #(
    .NREGS (NREGS),
    .RW    (RW)
  ) u_scoreboard (
    .clk     (clk),
    .nrst    (nrst),
    .set_en  (accept && issue.wr && (issue.rd != REG_ZERO)),
    .set_idx (issue.rd),
    .clr_en  (wen_int),
    .clr_idx (wb_rd),
    .busy    (busy_vec)
  );

  assign busy = busy_vec;

endmodule
